// File: rtl/multi_cycle_control_pkg.sv
// multi_cycle_control_pkg
//   Shared definitions for the LEGv8 multi-cycle sequencer:
//   - opcode constants (exact R-type/memory opcodes, casez patterns for CBZ and B)
//   - FSM state encoding (HALT only when MCC_ILLEGAL_TRAP_EN is defined)
//   - opcode class enumeration produced by mcc_opclass
//   - ALUOp and PCSrc encodings
package multi_cycle_control_pkg;

  // Opcode field = instruction bits [31:21]
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  // CBZ and B carry immediate bits inside [31:21]; only the prefix decodes.
  localparam logic [10:0] OP_CBZ  = 11'b10110100???;
  localparam logic [10:0] OP_B    = 11'b000101?????;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
`ifdef MCC_ILLEGAL_TRAP_EN
    , ST_HALT = 3'd5
`endif
  } state_t;

  typedef enum logic [2:0] {
    CL_RTYPE   = 3'd0,
    CL_LDUR    = 3'd1,
    CL_STUR    = 3'd2,
    CL_CBZ     = 3'd3,
    CL_B       = 3'd4,
    CL_ILLEGAL = 3'd5
  } opclass_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;  // address computation
  localparam logic [1:0] ALUOP_PASSB = 2'b01;  // pass B, used by CBZ
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;  // ALU control decodes funct

  localparam logic [1:0] PCSRC_SEQ    = 2'b00; // PC + 4
  localparam logic [1:0] PCSRC_BRANCH = 2'b01; // PC + (SignExt << 2)

endpackage

// File: rtl/mcc_opclass.sv
// mcc_opclass
//   Combinational opcode classifier for the multi-cycle sequencer.
//   Ports:
//     opcode  in  11  instruction bits [31:21]
//     opclass out     RTYPE / LDUR / STUR / CBZ / B / ILLEGAL
module mcc_opclass
  import multi_cycle_control_pkg::*;
(
  input  logic [10:0] opcode,
  output opclass_t    opclass
);

  always_comb begin
    opclass = CL_ILLEGAL;
    casez (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_ORR: opclass = CL_RTYPE;
      OP_LDUR:                        opclass = CL_LDUR;
      OP_STUR:                        opclass = CL_STUR;
      OP_CBZ:                         opclass = CL_CBZ;
      OP_B:                           opclass = CL_B;
      default:                        opclass = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// multi_cycle_control
//   Multi-cycle sequencer for the LEGv8 subset (LDUR, STUR, ADD, SUB, AND,
//   ORR, CBZ, B). Steps FETCH -> DECODE -> EXEC -> MEM -> WB over a shared
//   ALU and a variable-latency data memory, and counts retired instructions.
//   Optional feature macro: MCC_ILLEGAL_TRAP_EN (illegal opcode -> HALT,
//   adds the Illegal port); otherwise illegal opcodes retire as NOPs.
//   Ports:
//     CLK, Reset (synchronous, active-high)
//     Opcode[10:0], Zero, MemReady           inputs from the datapath
//     Reg2Loc, ALUSrc, MemToReg, RegWrite,
//     MemRead, MemWrite, ALUOp[1:0]          datapath controls
//     IRWrite, PCWrite, PCSrc[1:0]           per-step strobes
//     InstrDone, RetireCount[CNTW-1:0]       retirement pulse and counter
//     State[2:0]                             current state (debug)
//     Illegal                                only with MCC_ILLEGAL_TRAP_EN
module multi_cycle_control
  import multi_cycle_control_pkg::*;
#(
  parameter int CNTW = 32
)
(
  input  logic            CLK,
  input  logic            Reset,
  input  logic [10:0]     Opcode,
  input  logic            Zero,
  input  logic            MemReady,
  output logic            Reg2Loc,
  output logic            ALUSrc,
  output logic            MemToReg,
  output logic            RegWrite,
  output logic            MemRead,
  output logic            MemWrite,
  output logic [1:0]      ALUOp,
  output logic            IRWrite,
  output logic            PCWrite,
  output logic [1:0]      PCSrc,
  output logic            InstrDone,
  output logic [CNTW-1:0] RetireCount,
  output logic [2:0]      State
`ifdef MCC_ILLEGAL_TRAP_EN
  ,
  output logic            Illegal
`endif
);

  state_t         state_reg, state_next;
  logic [CNTW-1:0] count_reg;
  opclass_t       opclass;

  logic       reg2loc_c, alusrc_c, memtoreg_c, regwrite_c;
  logic       memread_c, memwrite_c, irwrite_c, retire_c;
  logic [1:0] aluop_c, pcsrc_c;
`ifdef MCC_ILLEGAL_TRAP_EN
  logic       illegal_c;
`endif

  mcc_opclass u_opclass (
    .opcode  (Opcode),
    .opclass (opclass)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_reg <= ST_FETCH;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire_c)
        count_reg <= count_reg + CNTW'(1);
    end
  end

  // Every retirement also loads the PC, so PCWrite and InstrDone are
  // both derived from retire_c below.
  always_comb begin
    state_next = state_reg;
    reg2loc_c  = 1'b0;
    alusrc_c   = 1'b0;
    memtoreg_c = 1'b0;
    regwrite_c = 1'b0;
    memread_c  = 1'b0;
    memwrite_c = 1'b0;
    irwrite_c  = 1'b0;
    retire_c   = 1'b0;
    aluop_c    = ALUOP_ADD;
    pcsrc_c    = PCSRC_SEQ;
`ifdef MCC_ILLEGAL_TRAP_EN
    illegal_c  = 1'b0;
`endif
    case (state_reg)
      ST_FETCH: begin
        irwrite_c  = 1'b1;
        state_next = ST_DECODE;
      end
      ST_DECODE: begin
        case (opclass)
          CL_B: begin
            retire_c   = 1'b1;
            pcsrc_c    = PCSRC_BRANCH;
            state_next = ST_FETCH;
          end
          CL_ILLEGAL: begin
`ifdef MCC_ILLEGAL_TRAP_EN
            state_next = ST_HALT;
`else
            // Unknown opcode is skipped as a NOP.
            retire_c   = 1'b1;
            state_next = ST_FETCH;
`endif
          end
          default: state_next = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (opclass)
          CL_RTYPE: begin
            aluop_c    = ALUOP_RTYPE;
            state_next = ST_WB;
          end
          CL_LDUR, CL_STUR: begin
            alusrc_c   = 1'b1;
            aluop_c    = ALUOP_ADD;
            state_next = ST_MEM;
          end
          CL_CBZ: begin
            reg2loc_c  = 1'b1;
            aluop_c    = ALUOP_PASSB;
            retire_c   = 1'b1;
            pcsrc_c    = Zero ? PCSRC_BRANCH : PCSRC_SEQ;
            state_next = ST_FETCH;
          end
          // Opcode is held stable from DECODE, so this only recovers
          // from a datapath fault: abandon the instruction silently.
          default: state_next = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        case (opclass)
          CL_LDUR: begin
            memread_c = 1'b1;
            if (MemReady)
              state_next = ST_WB;
          end
          CL_STUR: begin
            memwrite_c = 1'b1;
            reg2loc_c  = 1'b1;
            if (MemReady) begin
              retire_c   = 1'b1;
              state_next = ST_FETCH;
            end
          end
          default: state_next = ST_FETCH;
        endcase
      end
      ST_WB: begin
        regwrite_c = 1'b1;
        memtoreg_c = (opclass == CL_LDUR);
        retire_c   = 1'b1;
        state_next = ST_FETCH;
      end
`ifdef MCC_ILLEGAL_TRAP_EN
      ST_HALT: begin
        illegal_c  = 1'b1;
        state_next = ST_HALT;
      end
`endif
      default: state_next = ST_FETCH;
    endcase
  end

  // Reset masks every output except State in the same cycle, so an
  // interrupted instruction never shows a partial strobe.
  assign Reg2Loc     = ~Reset & reg2loc_c;
  assign ALUSrc      = ~Reset & alusrc_c;
  assign MemToReg    = ~Reset & memtoreg_c;
  assign RegWrite    = ~Reset & regwrite_c;
  assign MemRead     = ~Reset & memread_c;
  assign MemWrite    = ~Reset & memwrite_c;
  assign ALUOp       = Reset ? 2'b00 : aluop_c;
  assign IRWrite     = ~Reset & irwrite_c;
  assign PCWrite     = ~Reset & retire_c;
  assign PCSrc       = Reset ? 2'b00 : pcsrc_c;
  assign InstrDone   = ~Reset & retire_c;
  assign RetireCount = Reset ? '0 : count_reg;
  assign State       = state_reg;
`ifdef MCC_ILLEGAL_TRAP_EN
  assign Illegal     = ~Reset & illegal_c;
`endif

endmodule

// File: tb/tb_multi_cycle_control.sv
// tb_multi_cycle_control
//   Randomized bench for multi_cycle_control. For each instruction a small
//   reference model writes out the cycle-by-cycle trace the instruction must
//   produce (state, control vector, MemReady to drive), which is then played
//   against the DUT. RetireCount is tracked modulo 2^CNTW with a narrow
//   counter so wrap-around is exercised.
module tb_multi_cycle_control;

  localparam int CNTW = 4;

  localparam int K_R   = 0;
  localparam int K_LD  = 1;
  localparam int K_ST  = 2;
  localparam int K_CBZ = 3;
  localparam int K_B   = 4;
  localparam int K_ILL = 5;

  logic            CLK = 1'b0;
  logic            Reset;
  logic [10:0]     Opcode;
  logic            Zero;
  logic            MemReady;
  logic            Reg2Loc, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite;
  logic [1:0]      ALUOp;
  logic            IRWrite, PCWrite;
  logic [1:0]      PCSrc;
  logic            InstrDone;
  logic [CNTW-1:0] RetireCount;
  logic [2:0]      State;
`ifdef MCC_ILLEGAL_TRAP_EN
  logic            Illegal;
`endif

  always #5 CLK = ~CLK;

  multi_cycle_control #(.CNTW(CNTW)) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .Opcode      (Opcode),
    .Zero        (Zero),
    .MemReady    (MemReady),
    .Reg2Loc     (Reg2Loc),
    .ALUSrc      (ALUSrc),
    .MemToReg    (MemToReg),
    .RegWrite    (RegWrite),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .ALUOp       (ALUOp),
    .IRWrite     (IRWrite),
    .PCWrite     (PCWrite),
    .PCSrc       (PCSrc),
    .InstrDone   (InstrDone),
    .RetireCount (RetireCount),
    .State       (State)
`ifdef MCC_ILLEGAL_TRAP_EN
    ,
    .Illegal     (Illegal)
`endif
  );

  // {Reg2Loc,ALUSrc,MemToReg,RegWrite,MemRead,MemWrite,ALUOp,IRWrite,PCWrite,PCSrc,InstrDone}
  logic [12:0] obs_ctl;
  assign obs_ctl = {Reg2Loc, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite,
                    ALUOp, IRWrite, PCWrite, PCSrc, InstrDone};

  typedef struct packed {
    logic [2:0]  st;
    logic [12:0] ctl;
    logic        mr;
    logic        zb;
    logic        rst;
    logic        ill;
  } step_t;

  step_t plan[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    exp_count = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [12:0] c(input logic r2l, input logic alus, input logic m2r,
                                    input logic rw, input logic mrd, input logic mwr,
                                    input logic [1:0] aop, input logic irw, input logic pcw,
                                    input logic [1:0] pcs, input logic done);
    return {r2l, alus, m2r, rw, mrd, mwr, aop, irw, pcw, pcs, done};
  endfunction

  function automatic step_t mk(input logic [2:0] st, input logic [12:0] ctl,
                               input logic mr, input logic rst);
    step_t s;
    s.st  = st;
    s.ctl = ctl;
    s.mr  = mr;
    s.zb  = rnd();
    s.rst = rst;
    s.ill = 1'b0;
    return s;
  endfunction

  // Expected trace of one instruction, spelled out from the instruction's
  // step list (fetch, decode, then the class-specific remainder).
  task automatic plan_instr(input int cls, input int waits, input logic z);
    step_t s;
    plan.delete();
    plan.push_back(mk(3'd0, c(0,0,0,0,0,0,2'b00,1,0,2'b00,0), rnd(), 1'b0));
    case (cls)
      K_B:   plan.push_back(mk(3'd1, c(0,0,0,0,0,0,2'b00,0,1,2'b01,1), rnd(), 1'b0));
`ifdef MCC_ILLEGAL_TRAP_EN
      K_ILL: plan.push_back(mk(3'd1, 13'd0, rnd(), 1'b0));
`else
      K_ILL: plan.push_back(mk(3'd1, c(0,0,0,0,0,0,2'b00,0,1,2'b00,1), rnd(), 1'b0));
`endif
      default: plan.push_back(mk(3'd1, 13'd0, rnd(), 1'b0));
    endcase
    case (cls)
      K_R: begin
        plan.push_back(mk(3'd2, c(0,0,0,0,0,0,2'b10,0,0,2'b00,0), rnd(), 1'b0));
        plan.push_back(mk(3'd4, c(0,0,0,1,0,0,2'b00,0,1,2'b00,1), rnd(), 1'b0));
      end
      K_LD: begin
        plan.push_back(mk(3'd2, c(0,1,0,0,0,0,2'b00,0,0,2'b00,0), rnd(), 1'b0));
        for (int i = 0; i < waits; i++)
          plan.push_back(mk(3'd3, c(0,0,0,0,1,0,2'b00,0,0,2'b00,0), 1'b0, 1'b0));
        plan.push_back(mk(3'd3, c(0,0,0,0,1,0,2'b00,0,0,2'b00,0), 1'b1, 1'b0));
        plan.push_back(mk(3'd4, c(0,0,1,1,0,0,2'b00,0,1,2'b00,1), rnd(), 1'b0));
      end
      K_ST: begin
        plan.push_back(mk(3'd2, c(0,1,0,0,0,0,2'b00,0,0,2'b00,0), rnd(), 1'b0));
        for (int i = 0; i < waits; i++)
          plan.push_back(mk(3'd3, c(1,0,0,0,0,1,2'b00,0,0,2'b00,0), 1'b0, 1'b0));
        plan.push_back(mk(3'd3, c(1,0,0,0,0,1,2'b00,0,1,2'b00,1), 1'b1, 1'b0));
      end
      K_CBZ: begin
        s = mk(3'd2, c(1,0,0,0,0,0,2'b01,0,1,(z ? 2'b01 : 2'b00),1), rnd(), 1'b0);
        s.zb = z;
        plan.push_back(s);
      end
      default: ;
    endcase
  endtask

  // One plan entry = drive at a falling edge, check, then the rising edge.
  task automatic run_plan(input logic [10:0] op);
    foreach (plan[i]) begin
      @(negedge CLK);
      Reset    = plan[i].rst;
      Opcode   = op;
      Zero     = plan[i].zb;
      MemReady = plan[i].mr;
      #1;
      check("state", 32'(State), 32'(plan[i].st));
      check("ctl", 32'(obs_ctl), 32'(plan[i].ctl));
      check("count", 32'(RetireCount), plan[i].rst ? 32'd0 : 32'(exp_count));
`ifdef MCC_ILLEGAL_TRAP_EN
      check("illegal", 32'(Illegal), 32'(plan[i].ill));
`endif
      if (plan[i].rst)
        exp_count = 0;
      else if (plan[i].ctl[0])
        exp_count = (exp_count + 1) % (1 << CNTW);
    end
  endtask

  task automatic run_instr(input string name, input logic [10:0] op, input int cls,
                           input int waits, input logic z);
    plan_instr(cls, waits, z);
    run_plan(op);
    $display("instr %-4s op=%03h waits=%0d zero=%0b cycles=%0d retired=%0d",
             name, op, waits, z, plan.size(), exp_count);
  endtask

  function automatic logic [10:0] pick_op(input int cls);
    logic [10:0] rt [4];
    logic [10:0] il [5];
    rt = '{11'h458, 11'h658, 11'h450, 11'h550};
    il = '{11'h000, 11'h7FF, 11'h459, 11'h5B0, 11'h0C0};
    case (cls)
      K_R:     return rt[$urandom_range(0, 3)];
      K_LD:    return 11'h7C2;
      K_ST:    return 11'h7C0;
      K_CBZ:   return 11'h5A0 | 11'($urandom_range(0, 7));
      K_B:     return 11'h0A0 | 11'($urandom_range(0, 31));
      default: return il[$urandom_range(0, 4)];
    endcase
  endfunction

  initial begin
    string names [6];
    int    cls;
    step_t s;
    names = '{"RTYP", "LDUR", "STUR", "CBZ", "B", "ILL"};
    Reset = 1'b1; Opcode = 11'h000; Zero = 1'b0; MemReady = 1'b0;

    // Reset state: held in reset across two edges, outputs all zero.
    repeat (2) @(negedge CLK);
    #1;
    check("rst_state", 32'(State), 32'd0);
    check("rst_ctl", 32'(obs_ctl), 32'd0);
    check("rst_count", 32'(RetireCount), 32'd0);
    $display("instr RST  reset applied");

    // Directed cases.
    run_instr("ADD",  11'h458, K_R,   0, 1'b0);
    run_instr("LDUR", 11'h7C2, K_LD,  3, 1'b0);
    run_instr("CBZ",  11'h5A3, K_CBZ, 0, 1'b1);
    run_instr("CBZ",  11'h5A3, K_CBZ, 0, 1'b0);
    run_instr("B",    11'h0A5, K_B,   0, 1'b0);
    run_instr("STUR", 11'h7C0, K_ST,  0, 1'b0);

    // Reset in the second MEM wait cycle of an LDUR.
    plan_instr(K_LD, 3, 1'b0);
    while (plan.size() > 4) void'(plan.pop_back());
    plan.push_back(mk(3'd3, 13'd0, 1'b0, 1'b1));
    run_plan(11'h7C2);
    $display("instr LDUR op=7c2 reset during MEM wait, retired=%0d", exp_count);
    run_instr("ADD",  11'h458, K_R,   0, 1'b0);

`ifdef MCC_ILLEGAL_TRAP_EN
    plan_instr(K_ILL, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      s = mk(3'd5, 13'd0, rnd(), 1'b0);
      s.ill = 1'b1;
      plan.push_back(s);
    end
    plan.push_back(mk(3'd5, 13'd0, 1'b0, 1'b1));
    run_plan(11'h000);
    $display("instr ILL  op=000 halted until reset, retired=%0d", exp_count);
`else
    run_instr("ILL",  11'h000, K_ILL, 0, 1'b0);
`endif

    // Randomized instruction stream; the narrow counter wraps several times.
    for (int n = 0; n < 80; n++) begin
`ifdef MCC_ILLEGAL_TRAP_EN
      cls = $urandom_range(0, 4);
`else
      cls = $urandom_range(0, 5);
`endif
      run_instr(names[cls], pick_op(cls), cls, $urandom_range(0, 3), rnd());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control.md
# multi_cycle_control

Multi-cycle sequencer for the LEGv8 subset datapath: LDUR, STUR, ADD, SUB, AND, ORR, CBZ and B. It replaces the single-cycle decoder when the datapath is split into fetch/decode/execute/memory/writeback steps over a shared ALU and a variable-latency data memory. It drives the same datapath controls, plus per-step strobes (IRWrite, PCWrite) and a retired-instruction counter.

## Interface
- CNTW, default 32: width of the retired-instruction counter.
- CLK  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high.
- Opcode  in  11  instruction bits [31:21] from the IR; valid from DECODE until the next FETCH edge.
- Zero  in  1  ALU zero flag, valid in EXEC.
- MemReady  in  1  data-memory completion, sampled only in MEM.
- Reg2Loc, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite  out  1 each  datapath controls, same meaning as the single-cycle control.
- ALUOp  out  2  00 add (address), 01 pass-B/CBZ, 10 R-type funct.
- IRWrite  out  1  load IR at end of cycle.
- PCWrite  out  1  load PC at end of cycle.
- PCSrc  out  2  00 PC+4, 01 PC+(SignExt<<2); 10/11 unused (never driven).
- InstrDone  out  1  one-cycle pulse on retirement.
- RetireCount  out  CNTW  retired instructions; wraps modulo 2^CNTW.
- State  out  3  current state (debug).
- Illegal  out  1  only with MCC_ILLEGAL_TRAP_EN.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5 (HALT exists only with the macro).
- FETCH: IRWrite=1 → DECODE.
- DECODE: register read. B: retire here (PCWrite=1, PCSrc=01) → FETCH. Other legal opcodes → EXEC.
- EXEC: ALU. R-type: ALUSrc=0, ALUOp=10 → WB. LDUR/STUR: ALUSrc=1, ALUOp=00 → MEM. CBZ: Reg2Loc=1, ALUOp=01; retire with PCSrc = Zero ? 01 : 00 → FETCH.
- MEM: LDUR holds MemRead=1, STUR holds MemWrite=1 (and Reg2Loc=1) until MemReady=1. On MemReady, LDUR → WB. STUR retires (PCSrc=00) → FETCH.
- WB: RegWrite=1, MemToReg=1 for LDUR and 0 for R-type; retires (PCSrc=00) → FETCH.
- Retirement cycle: PCWrite=1, InstrDone=1, RetireCount increments on that edge.
- Controls not listed for a state are 0. The block never outputs X.
- Outputs are a function of State and the Opcode class. Zero and MemReady affect only PCSrc and the next-state/retire decision.

## Timing
- Minimum cycles per instruction, with MemReady already high: B 2, CBZ 3, R-type 4, STUR 4, LDUR 5.
- Each MemReady=0 cycle in MEM adds one cycle. There is no timeout.
- MemReady outside MEM is ignored.
- While Reset=1, every output except State is forced to 0 combinationally. The first edge with Reset=1 sets State=FETCH and RetireCount=0.
- Reset mid-instruction (including MEM waiting on MemReady) drops all strobes in the same cycle. No partial retirement or count is recorded.
- RetireCount wraps from all-ones to 0 on retirement, with no flag.

## Configuration
- MCC_ILLEGAL_TRAP_EN defined: an unrecognised opcode in DECODE → HALT. HALT drives Illegal=1 and all strobes 0, and only Reset exits it.
- MCC_ILLEGAL_TRAP_EN undefined: an unrecognised opcode retires in DECODE as a NOP (PCWrite=1, PCSrc=00, InstrDone=1, count increments) → FETCH. There is no Illegal port and no HALT state.

## Structure
- Shared package holds:
  - the opcode constants, including CBZ and B casez patterns;
  - the state encoding;
  - ALUOp and PCSrc encodings.
- One sub-module, mcc_opclass: combinational Opcode → class (RTYPE, LDUR, STUR, CBZ, B, ILLEGAL) using casez.

## Test plan
- ADD (Opcode 0x458), MemReady=1: State 0→1→2→4→0. RegWrite=1 only in WB with MemToReg=0. InstrDone once. RetireCount 0→1.
- LDUR (0x7C2), MemReady low 3 cycles in MEM: MemRead=1 for 4 consecutive cycles, then WB with MemToReg=1. Total 8 cycles.
- CBZ (0x5A3) with Zero=1: retire in EXEC, PCSrc=01. Repeat with Zero=0: PCSrc=00. Both take 3 cycles.
- B (0x0A5) back-to-back with STUR (0x7C0): B retires in cycle 2 with PCSrc=01. STUR MemWrite=1 only in MEM and RegWrite never asserts.
- Reset asserted in the second MEM wait cycle of LDUR: same cycle all strobes are 0. Next cycle State=0, RetireCount=0.
- Opcode 0x000: with the macro, HALT, Illegal=1, stays until Reset. Without the macro, NOP retires in 2 cycles.
